// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, legality check,
// sequencer state encoding and the packed command word.
package alu_pkg;

    localparam logic [3:0] OP_ADD      = 4'd1;
    localparam logic [3:0] OP_SUB      = 4'd2;
    localparam logic [3:0] OP_INC      = 4'd3;
    localparam logic [3:0] OP_DEC      = 4'd4;
    localparam logic [3:0] OP_OR       = 4'd5;
    localparam logic [3:0] OP_AND      = 4'd6;
    localparam logic [3:0] OP_XOR      = 4'd7;
    localparam logic [3:0] OP_SHR      = 4'd8;
    localparam logic [3:0] OP_SHL      = 4'd9;
    localparam logic [3:0] OP_ONESCOMP = 4'd10;
    localparam logic [3:0] OP_TWOSCOMP = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
    } alu_cmd_t;

    function automatic logic opcode_legal(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_TWOSCOMP);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of ALU command words with full/empty flags.
// The head entry is read combinationally so it can drive the ALU directly.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t wr_data,
    input  logic     pop,
    output alu_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    alu_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 8-bit ALU: buffers commands, issues one per pass,
// registers result/flags and keeps an accumulator. ALU_CMD_SEQ_STATS_EN adds counters.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_use_acc,
    output logic [7:0]  alu_in_a,
    output logic [7:0]  alu_in_b,
    output logic [3:0]  alu_opcode,
    input  logic [7:0]  alu_out,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_zero,
    output logic        res_carry,
    output logic        res_err,
    output logic [7:0]  acc
`ifdef ALU_CMD_SEQ_STATS_EN
    ,
    output logic [15:0] stat_cmds,
    output logic [15:0] stat_carries,
    output logic [7:0]  stat_errs
`endif
);

    seq_state_t state_reg, state_next;
    alu_cmd_t   cmd_in;
    alu_cmd_t   head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_fire;
    logic       head_legal;
    logic       res_valid_reg;
    logic [7:0] res_data_reg;
    logic       res_zero_reg;
    logic       res_carry_reg;
    logic       res_err_reg;
    logic [7:0] acc_reg;

    assign cmd_in.opcode  = cmd_opcode;
    assign cmd_in.a       = cmd_a;
    assign cmd_in.b       = cmd_b;
    assign cmd_in.use_acc = cmd_use_acc;

    assign cmd_ready  = !fifo_full;
    assign push_fire  = cmd_valid && !fifo_full;
    assign head_legal = opcode_legal(head.opcode);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid),
        .wr_data (cmd_in),
        .pop     (state_reg == ST_ISSUE),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        alu_opcode = 4'b0000;
        alu_in_a   = 8'h00;
        alu_in_b   = 8'h00;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                alu_opcode = head.opcode;
                alu_in_b   = head.b;
                alu_in_a   = head.use_acc ? acc_reg : head.a;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // A command arriving this very cycle is visible in the FIFO next cycle.
                if (res_ready) state_next = (!fifo_empty || push_fire) ? ST_ISSUE : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= 8'h00;
            res_zero_reg  <= 1'b0;
            res_carry_reg <= 1'b0;
            res_err_reg   <= 1'b0;
            acc_reg       <= 8'h00;
        end else if (state_reg == ST_ISSUE) begin
            res_valid_reg <= 1'b1;
            if (head_legal) begin
                res_data_reg  <= alu_out;
                res_zero_reg  <= alu_zero;
                res_carry_reg <= alu_carry;
                res_err_reg   <= 1'b0;
                acc_reg       <= alu_out;
            end else begin
                // Illegal opcodes report a clean zero result and leave acc untouched.
                res_data_reg  <= 8'h00;
                res_zero_reg  <= 1'b1;
                res_carry_reg <= 1'b0;
                res_err_reg   <= 1'b1;
            end
        end else if ((state_reg == ST_HOLD) && res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_zero  = res_zero_reg;
    assign res_carry = res_carry_reg;
    assign res_err   = res_err_reg;
    assign acc       = acc_reg;

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0] stat_cmds_reg;
    logic [15:0] stat_carries_reg;
    logic [7:0]  stat_errs_reg;
    logic        res_fire;

    assign res_fire = res_valid_reg && res_ready;

    // Saturating counters of results actually accepted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cmds_reg    <= '0;
            stat_carries_reg <= '0;
            stat_errs_reg    <= '0;
        end else if (res_fire) begin
            if (stat_cmds_reg != '1) stat_cmds_reg <= stat_cmds_reg + 16'd1;
            if (res_carry_reg && (stat_carries_reg != '1)) stat_carries_reg <= stat_carries_reg + 16'd1;
            if (res_err_reg && (stat_errs_reg != '1)) stat_errs_reg <= stat_errs_reg + 8'd1;
        end
    end

    assign stat_cmds    = stat_cmds_reg;
    assign stat_carries = stat_carries_reg;
    assign stat_errs    = stat_errs_reg;
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the 8-bit ALU.
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per pass to the ALU's combinational inputs, captures the result and flags into registers, and presents them downstream over a second valid/ready handshake.
- Keeps an 8-bit accumulator so chained operations can use the previous result as operand A.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_opcode  input  4  ALU opcode.
- cmd_a  input  8  operand A (immediate).
- cmd_b  input  8  operand B.
- cmd_use_acc  input  1  1 = operand A taken from the accumulator, cmd_a ignored.
- alu_in_a  output  8  to ALU in_a.
- alu_in_b  output  8  to ALU in_b.
- alu_opcode  output  4  to ALU opcode.
- alu_out  input  8  ALU result (combinational, same cycle).
- alu_zero  input  1  ALU zero flag.
- alu_carry  input  1  ALU carry flag.
- res_valid  output  1  result held.
- res_ready  input  1  downstream accepts.
- res_data  output  8  captured result.
- res_zero  output  1  captured zero flag.
- res_carry  output  1  captured carry flag.
- res_err  output  1  captured command had an illegal opcode.
- acc  output  8  current accumulator.

Behaviour:
- Reset (async, rst_n=0): FIFO empty; FSM in IDLE; acc=0; res_valid=0; res_data=0; res_zero=0; res_carry=0; res_err=0. cmd_ready=1 once rst_n deasserts.
- Push: occurs on cmd_valid && cmd_ready. When full, cmd_ready=0 and no write occurs.
- Push/pop in the same cycle: both take effect; count unchanged.
- Pointers: wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: alu_opcode=4'b0000, alu_in_a=0, alu_in_b=0. If the FIFO is non-empty, go to ISSUE next cycle.
  - ISSUE:
    - ALU drive: head entry drives alu_opcode and alu_in_b; alu_in_a = use_acc ? acc : a.
    - Capture at the clock edge: res_data<=alu_out, res_zero<=alu_zero, res_carry<=alu_carry, res_err<=illegal.
    - Accumulator: acc<=alu_out only if the opcode is legal.
    - Pop the head; set res_valid<=1; go to HOLD.
  - HOLD: outputs stable while res_valid && !res_ready. On res_ready, clear res_valid. Next state is ISSUE if the FIFO is non-empty (including an entry pushed this cycle), otherwise IDLE.
- Legal opcodes: 1..11. Opcodes 0 and 12..15 are illegal: res_err=1, res_data=0, res_zero=1, res_carry=0, acc unchanged.
- Latency: command pushed at edge N issues in cycle N+1 and is captured at edge N+2. res_valid is high after edge N+2.
- Throughput: one result per 2 cycles when res_ready is held high.
- Data dependency: a use_acc command always sees the accumulator written by the preceding command, since issue and capture are serialised.
- Reset mid-operation: pending FIFO entries and any held result are discarded; the accumulator returns to 0.
- cmd_* inputs: ignored while cmd_ready=0.
- Handshake rule: res_valid never depends combinationally on res_ready.

Optional Feature:
- Macro: ALU_CMD_SEQ_STATS_EN.
- When defined, adds three outputs:
  - stat_cmds (16 bits): results accepted downstream.
  - stat_carries (16 bits): accepted results with res_carry=1.
  - stat_errs (8 bits): accepted results with res_err=1.
- All three counters saturate at all-ones, not wrap, and reset to 0.
- Without the macro: no ports, no counter logic; behaviour otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit opcode constants (ADD=1, SUB=2, INC=3, DEC=4, OR=5, AND=6, XOR=7, SHR=8, SHL=9, ONESCOMP=10, TWOSCOMP=11).
  - opcode_legal() function.
  - FSM state enum.
  - Packed command struct {opcode, a, b, use_acc}, 21 bits.
- One sub-module: alu_cmd_fifo (DEPTH-entry synchronous FIFO of the command struct with full/empty, async active-low reset).

Test Plan:
- ADD a=0x7F b=0x01, res_ready=1 -> res_data=0x80, carry=0, zero=0, err=0; res_valid 2 cycles after push; acc=0x80.
- ADD 0xFF+0x01, then INC with use_acc=1 -> first result 0x00 carry=1 zero=1; second result 0x01, acc=0x01.
- res_ready=0, push 5 commands -> cmd_ready drops after 4 are queued plus 1 in HOLD. Releasing res_ready drains all results in push order with no loss or duplication.
- opcode 4'hC -> res_err=1, res_data=0x00, zero=1, acc unchanged (0x2A preloaded via ADD 0x2A+0).
- rst_n pulsed low in HOLD with 2 entries queued -> res_valid=0 immediately (async), FIFO empty, acc=0, cmd_ready=1 after release.
- With ALU_CMD_SEQ_STATS_EN: 3 ADDs (one carrying) plus 1 illegal accepted -> stat_cmds=4, stat_carries=1, stat_errs=1.
